sensor_frame_engine: RTL and testbench

- Multi-channel successor to the single-sensor node datapath: samples CH 8-bit sensor channels on a programmable period and stores them in a circular sample buffer.
- Emits framed packets to the radio as a byte stream: sync, node ID, sequence, length, payload, XOR checksum.
- Uses a valid/ready handshake.
- Sits between the sensor front-ends and the radio transmitter, replacing the separate controller/memory/packetiser path for transmit.

---
 rtl/sensor_frame_engine.sv | 195 +++++++++++++++++++
 tb/tb_sensor_frame_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_engine.sv
// sensor_frame_engine
//   Samples CH 8-bit sensor channels every PERIOD clocks into a circular
//   buffer and streams framed packets to the radio over valid/ready:
//     A5 | NODE_ID | seq | len | payload[len] | xor(ID..payload)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   enable       sampling enable (clears the tick counter when low)
//   environment  channel k on bits [8k+7:8k]
//   flush        (SNF_FLUSH_EN only) send a short frame of what is buffered
//   tx_data      frame byte
//   tx_valid     tx_data valid
//   tx_ready     radio accepts byte
//   fill_level   registered buffer occupancy
//   overrun_cnt  dropped sample sets, saturating at 255
//   frame_active frame FSM not idle
//
// Build option
//   SNF_FLUSH_EN  adds the flush input and short-frame support.
//
// state     | meaning
// S_IDLE    | waiting for a full frame (or flush) in the buffer
// S_SYNC    | presenting sync byte A5
// S_ID      | presenting NODE_ID
// S_SEQ     | presenting sequence number
// S_LEN     | presenting payload length
// S_PAYLOAD | presenting buffer head, popped on each transfer
// S_CSUM    | presenting running XOR; seq increments on transfer
module sensor_frame_engine #(
  parameter int          CH        = 4,
  parameter int          DEPTH     = 16,
  parameter int          FRAME_LEN = 8,
  parameter int          PERIOD    = 1000,
  parameter logic [7:0]  NODE_ID   = 8'h01
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [CH*8-1:0]          environment,
`ifdef SNF_FLUSH_EN
  input  logic                     flush,
`endif
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [7:0]               overrun_cnt,
  output logic                     frame_active
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int TW  = $clog2(PERIOD);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_ID, S_SEQ, S_LEN, S_PAYLOAD, S_CSUM
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt;
  logic            scan_active;
  logic [CHW-1:0]  scan_ch;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      seq, csum, len_reg, pay_cnt;

  logic tick, space_ok, push, pop, xfer, start_frame;
  logic [7:0] start_len;

  assign tick     = enable && (tick_cnt == TW'(PERIOD - 1));
  assign space_ok = (count <= CW'(DEPTH - CH));
  assign push     = scan_active;
  assign xfer     = tx_valid && tx_ready;
  assign pop      = xfer && (state == S_PAYLOAD);

  assign fill_level   = count;
  assign frame_active = (state != S_IDLE);

  // A full frame always takes priority; flush only shortens an otherwise idle wait.
  always_comb begin
    start_frame = (count >= CW'(FRAME_LEN));
    start_len   = 8'(FRAME_LEN);
`ifdef SNF_FLUSH_EN
    if (!start_frame && flush && (count != '0)) begin
      start_frame = 1'b1;
      start_len   = 8'(count);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) tick_cnt <= '0;
    else if (tick)      tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + 1'b1;
  end

  // Space is checked once at the tick so a set is either written whole or dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_active <= 1'b0;
      scan_ch     <= '0;
      overrun_cnt <= 8'd0;
    end else begin
      if (scan_active) begin
        if (scan_ch == CHW'(CH - 1)) begin
          scan_active <= 1'b0;
          scan_ch     <= '0;
        end else begin
          scan_ch <= scan_ch + 1'b1;
        end
      end else if (tick) begin
        if (space_ok)                 scan_active <= 1'b1;
        else if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= environment[scan_ch*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      seq     <= 8'd0;
      csum    <= 8'd0;
      len_reg <= 8'd0;
      pay_cnt <= 8'd0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start_frame) len_reg <= start_len;
      if (state == S_SYNC)
        csum <= 8'd0;
      else if (xfer && (state == S_ID || state == S_SEQ || state == S_LEN || state == S_PAYLOAD))
        csum <= csum ^ tx_data;
      if (state != S_PAYLOAD) pay_cnt <= 8'd0;
      else if (xfer)          pay_cnt <= pay_cnt + 8'd1;
      if (xfer && state == S_CSUM) seq <= seq + 8'd1;
    end
  end

  always_comb begin
    state_n  = state;
    tx_valid = 1'b0;
    tx_data  = 8'd0;
    case (state)
      S_IDLE:    if (start_frame) state_n = S_SYNC;
      S_SYNC: begin
        tx_valid = 1'b1; tx_data = 8'hA5;
        if (xfer) state_n = S_ID;
      end
      S_ID: begin
        tx_valid = 1'b1; tx_data = NODE_ID;
        if (xfer) state_n = S_SEQ;
      end
      S_SEQ: begin
        tx_valid = 1'b1; tx_data = seq;
        if (xfer) state_n = S_LEN;
      end
      S_LEN: begin
        tx_valid = 1'b1; tx_data = len_reg;
        if (xfer) state_n = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        tx_valid = 1'b1; tx_data = mem[rd_ptr];
        if (xfer && pay_cnt == len_reg - 8'd1) state_n = S_CSUM;
      end
      S_CSUM: begin
        tx_valid = 1'b1; tx_data = csum;
        if (xfer) state_n = S_IDLE;
      end
      default:   state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sensor_frame_engine.sv
module tb_sensor_frame_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] environment = 32'h04030201;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [4:0]  fill_level;
  logic [7:0]  overrun_cnt;
  logic        frame_active;
`ifdef SNF_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] cap [0:31];
  int ncap;

  always #5 clk = ~clk;

  sensor_frame_engine #(
    .CH(4), .DEPTH(16), .FRAME_LEN(8), .PERIOD(20), .NODE_ID(8'h3C)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .environment(environment),
`ifdef SNF_FLUSH_EN
    .flush(flush),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fill_level(fill_level), .overrun_cnt(overrun_cnt), .frame_active(frame_active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Expected byte i of a frame: payload k is channel (k mod 4)+1.
  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] s, input int len);
    logic [7:0] c;
    if (i == 0) return 8'hA5;
    if (i == 1) return 8'h3C;
    if (i == 2) return s;
    if (i == 3) return 8'(len);
    if (i < 4 + len) return 8'((i - 4) % 4 + 1);
    c = 8'h3C ^ s ^ 8'(len);
    for (int k = 0; k < len; k++) c = c ^ 8'(k % 4 + 1);
    return c;
  endfunction

  // Records n transfers; checks that a stalled byte holds its value.
  task automatic capture(input int n, input bit toggle, input int limit);
    int cyc = 0;
    logic [7:0] prev_d = 8'd0;
    bit prev_stall = 1'b0;
    ncap = 0;
    while (ncap < n && cyc < limit) begin
      if (toggle) tx_ready = ((cyc / 3) % 2) == 0;
      if (prev_stall) begin
        check("stall_data", {24'd0, tx_data}, {24'd0, prev_d});
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
      end
      if (tx_valid && tx_ready) begin
        cap[ncap] = tx_data;
        ncap++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_d = tx_data;
      step();
      cyc++;
    end
    if (ncap < n) check("capture_timeout", ncap, n);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] s, input int len);
    for (int i = 0; i < len + 5; i++)
      check($sformatf("%s_b%0d", tag, i), {24'd0, cap[base + i]}, {24'd0, exp_byte(i, s, len)});
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; tx_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_fill(input int lvl, input int limit);
    int cyc = 0;
    while (int'(fill_level) < lvl && cyc < limit) begin step(); cyc++; end
    check("wait_fill", fill_level, lvl);
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_fill", fill_level, 0);
    check("rst_ovr", overrun_cnt, 0);
    check("rst_active", frame_active, 0);

    // normal frame after two scans
    enable = 1'b1; tx_ready = 1'b1;
    wait_fill(8, 100);
    enable = 1'b0;
    capture(13, 1'b0, 100);
    check_frame("norm", 0, 8'h00, 8);
    check("norm_csum_lit", cap[12], 8'h34);
    check("norm_fill", fill_level, 0);
    check("norm_idle", frame_active, 0);

    // backpressure, two frames
    do_reset();
    enable = 1'b1;
    capture(26, 1'b1, 800);
    enable = 1'b0;
    check_frame("bp1", 0, 8'h00, 8);
    check_frame("bp2", 13, 8'h01, 8);
    check("bp2_csum_lit", cap[25], 8'h35);

    // overrun
    do_reset();
    enable = 1'b1; tx_ready = 1'b0;
    for (int i = 0; i < 125; i++) step();
    check("ovr_fill", fill_level, 16);
    check("ovr_cnt", overrun_cnt, 2);
    check("ovr_valid", tx_valid, 1);
    check("ovr_data", tx_data, 8'hA5);
    enable = 1'b0;

    // reset mid-payload
    do_reset();
    enable = 1'b1; tx_ready = 1'b1;
    capture(6, 1'b0, 200);
    check("mid_valid_pre", tx_valid, 1);
    check("mid_p3", tx_data, 8'h03);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_valid", tx_valid, 0);
    check("mid_fill", fill_level, 0);
    check("mid_ovr", overrun_cnt, 0);
    capture(13, 1'b0, 200);
    check_frame("mid_next", 0, 8'h00, 8);

    // sequence wrap over 257 frames
    do_reset();
    enable = 1'b1; tx_ready = 1'b1;
    for (int f = 1; f <= 257; f++) begin
      capture(13, 1'b0, 300);
      if (f == 256) check("wrap_seq256", cap[2], 8'hFF);
      if (f == 257) begin
        check("wrap_seq257", cap[2], 8'h00);
        check("wrap_csum257", cap[12], 8'h34);
      end
    end
    check("wrap_ovr", overrun_cnt, 0);
    enable = 1'b0;

`ifdef SNF_FLUSH_EN
    // short frame from flush
    do_reset();
    enable = 1'b1; tx_ready = 1'b1;
    wait_fill(4, 60);
    enable = 1'b0;
    step();
    check("fl_idle", frame_active, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    capture(9, 1'b0, 60);
    check_frame("flush", 0, 8'h00, 4);
    check("fl_csum_lit", cap[8], 8'h3C);
    check("fl_fill", fill_level, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
